audio_volume_ramp: RTL and testbench
====================================

Name: audio_volume_ramp

Overview:
- Parametrised N-channel successor to the fixed 4-bit stereo volume stage in the audio sink path.
- Adds key-driven volume control with 2-FF sync, single-step-on-press and auto-repeat.
- Adds per-sample gain ramping so volume changes and mute produce no zipper noise, plus signed saturation with per-channel clip flags.
- Sits between the ADC read / DSP path and the DAC write driver; runs on the 50 MHz system clock, sample-qualified by a strobe.

Parameters:
- CHANNELS, 2, number of audio channels packed in iDATA/oDATA (channel 0 in LSBs).
- WIDTH, 16, signed sample width per channel.
- VOL_BITS, 4, volume index width; VOL_MAX = 2^VOL_BITS-1.
- VOL_INIT, 8, volume after reset; with GAIN_SHIFT=3 this is unity gain.
- GAIN_SHIFT, 3, gain = vol / 2^GAIN_SHIFT.
- RAMP_BITS, 4, fine gain bits; one volume step ramps over 2^RAMP_BITS strobes.
- REPEAT_TICKS, 4194304, clocks between auto-repeat steps while a key is held.

Ports:
- iCLK  input  1  system clock.
- iRST_N  input  1  reset, synchronous, active-low.
- iEN  input  1  volume-key enable; low ignores keys.
- iUP_N  input  1  volume-up key, active-low, asynchronous.
- iDN_N  input  1  volume-down key, active-low, asynchronous.
- iMUTE  input  1  level, mute request.
- iSTROBE  input  1  one-cycle sample valid.
- iDATA  input  CHANNELS*WIDTH  signed samples.
- oDATA  output  CHANNELS*WIDTH  scaled, saturated samples.
- oVALID  output  1  oDATA valid pulse.
- oSAT  output  CHANNELS  per-channel clip flag for the current oDATA.
- oVOL  output  VOL_BITS  current volume index.
- oRAMPING  output  1  high while current gain differs from target.

Behaviour:
- Reset (iRST_N low at posedge iCLK) sets:
  - vol=VOL_INIT and cur=VOL_INIT<<RAMP_BITS, so there is no ramp out of reset.
  - oDATA=0, oVALID=0, oSAT=0, oRAMPING=0.
  - Repeat counter=0, sync flops=released (1), pipeline flushed.
  - Reset mid-pipeline drops in-flight samples; no oVALID follows.
- Key sync: each key passes through 2 FFs. A press is detected on the synced falling edge.
- Key stepping (iEN=1):
  - On press detect, step vol once. Repeat counter clears, then counts while the key is held.
  - Each time the counter reaches REPEAT_TICKS-1: step again, and the counter wraps to 0.
  - Release clears the counter.
  - Both keys held: no step; counter held at 0.
  - Up clamps at VOL_MAX; down clamps at 0. A step at the limit is a no-op.
- iEN=0: steps suppressed, counter held at 0, sync flops still run. Raising iEN while a key is held does not step until the next press edge.
- Target gain: tgt = 0 if iMUTE, else vol<<RAMP_BITS (width VOL_BITS+RAMP_BITS, unsigned). Mute never changes vol.
- Ramp: on each iSTROBE cycle, cur moves ±1 toward tgt; no change if equal. Gain is never updated without a strobe.
  - oRAMPING = (cur != tgt), registered.
- Datapath, 2-stage pipeline:
  - Stage 1, on iSTROBE: per channel, p = signed(iDATA_ch) * cur, using cur before this cycle's ramp update. p is WIDTH+VOL_BITS+RAMP_BITS+1 bits signed.
  - Stage 2: s = p >>> (GAIN_SHIFT+RAMP_BITS), arithmetic, truncating toward −inf.
  - Saturate s to [−2^(WIDTH−1), 2^(WIDTH−1)−1]; oSAT_ch=1 iff clipped.
  - oDATA/oSAT register here; oVALID pulses 2 clocks after iSTROBE.
  - oDATA/oSAT hold their values between pulses.
- Throughput: iSTROBE may assert every cycle; fully pipelined, no backpressure.
- Simultaneous events:
  - A key step and iSTROBE in the same cycle: the strobe ramps toward the old tgt; the new tgt applies from the next cycle.
  - A mute toggle with iSTROBE behaves the same way.

Test Plan:
- Reset, vol=8, iDATA ch0=0x1234, ch1=0xEDCC, single strobe → oVALID exactly 2 clocks later; oDATA ch0=0x1234, ch1=0xEDCC; oSAT=0; oRAMPING=0.
- REPEAT_TICKS=8; hold iUP_N low for 30 clocks after press detect → vol steps at detect and at +8/+16/+24, giving oVOL=12. Then hold iDN_N for 200 clocks → oVOL clamps at 0 with no wrap. Both keys held → no change.
- From vol=8, one up press then 20 strobes → cur goes 128→144 over 16 strobes; oRAMPING drops after the 16th strobe; output gain reaches 9/8.
- vol=15 settled (cur=240), ch0=20000, ch1=−32768 → oDATA ch0=32767, ch1=−32768; oSAT=2'b11. ch0=1000 → 1875 with oSAT[0]=0.
- From vol=8, assert iMUTE with continuous strobes → gain reaches 0 after 128 strobes (oDATA=0) while oVOL stays 8. Deassert iMUTE → ramps back to 128 in 128 strobes.
- iRST_N low for 1 clock mid-ramp with a strobe in flight → no oVALID pulse; oVOL=8; cur=128; oDATA=0. iEN=0 with key presses → oVOL unchanged.

Source files
------------

// File: rtl/audio_volume_ramp.sv
// rtl/audio_volume_ramp.sv - N-channel volume stage with key control, gain ramping and saturation
module audio_volume_ramp #(
    parameter int CHANNELS     = 2,
    parameter int WIDTH        = 16,
    parameter int VOL_BITS     = 4,
    parameter int VOL_INIT     = 8,
    parameter int GAIN_SHIFT   = 3,
    parameter int RAMP_BITS    = 4,
    parameter int REPEAT_TICKS = 4194304
) (
    input  logic                      iCLK,
    input  logic                      iRST_N,
    input  logic                      iEN,
    input  logic                      iUP_N,
    input  logic                      iDN_N,
    input  logic                      iMUTE,
    input  logic                      iSTROBE,
    input  logic [CHANNELS*WIDTH-1:0] iDATA,
    output logic [CHANNELS*WIDTH-1:0] oDATA,
    output logic                      oVALID,
    output logic [CHANNELS-1:0]       oSAT,
    output logic [VOL_BITS-1:0]       oVOL,
    output logic                      oRAMPING
);

    localparam int TW = VOL_BITS + RAMP_BITS;
    localparam int PW = WIDTH + TW + 1;
    localparam int SH = GAIN_SHIFT + RAMP_BITS;
    localparam int CW = (REPEAT_TICKS > 1) ? $clog2(REPEAT_TICKS) : 1;

    localparam logic [VOL_BITS-1:0] VOL_MAX  = '1;
    localparam logic [VOL_BITS-1:0] VOL_RST  = VOL_BITS'(VOL_INIT);
    localparam logic [TW-1:0]       CUR_RST  = {VOL_RST, {RAMP_BITS{1'b0}}};
    localparam logic [CW-1:0]       CNT_LAST = CW'(REPEAT_TICKS - 1);
    localparam logic [WIDTH-1:0]    S_MAX    = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0]    S_MIN    = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]          up_sync, dn_sync;
    logic                up_last, dn_last;
    logic [VOL_BITS-1:0] vol, vol_nxt;
    logic [CW-1:0]       cnt, cnt_nxt;
    logic                armed, armed_nxt;
    logic                mute_q;
    logic [TW-1:0]       cur, cur_nxt, tgt, tgt_nxt;
    logic                v1;
    logic                up_held, dn_held, up_press, dn_press, step_up, step_dn;
    logic [CHANNELS*WIDTH-1:0] sat_data;
    logic [CHANNELS-1:0]       sat_flag;

    assign up_held  = ~up_sync[1];
    assign dn_held  = ~dn_sync[1];
    assign up_press = up_held & up_last;
    assign dn_press = dn_held & dn_last;

    // armed blocks auto-repeat for a key that was already down when iEN rose
    always_comb begin
        vol_nxt   = vol;
        cnt_nxt   = '0;
        armed_nxt = 1'b0;
        step_up   = 1'b0;
        step_dn   = 1'b0;
        if (iEN && (up_held ^ dn_held)) begin
            if (up_press || dn_press) begin
                step_up   = up_press;
                step_dn   = dn_press;
                armed_nxt = 1'b1;
            end else if (armed) begin
                armed_nxt = 1'b1;
                if (cnt == CNT_LAST) begin
                    step_up = up_held;
                    step_dn = dn_held;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
        end
        if (step_up && vol != VOL_MAX) begin
            vol_nxt = vol + 1'b1;
        end else if (step_dn && vol != '0) begin
            vol_nxt = vol - 1'b1;
        end
    end

    // target uses registered mute/vol so same-cycle events apply from the next cycle
    always_comb begin
        tgt     = mute_q ? '0 : {vol, {RAMP_BITS{1'b0}}};
        tgt_nxt = iMUTE ? '0 : {vol_nxt, {RAMP_BITS{1'b0}}};
        cur_nxt = cur;
        if (iSTROBE) begin
            if (cur < tgt) begin
                cur_nxt = cur + 1'b1;
            end else if (cur > tgt) begin
                cur_nxt = cur - 1'b1;
            end
        end
    end

    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            up_sync  <= 2'b11;
            dn_sync  <= 2'b11;
            up_last  <= 1'b1;
            dn_last  <= 1'b1;
            vol      <= VOL_RST;
            cnt      <= '0;
            armed    <= 1'b0;
            mute_q   <= 1'b0;
            cur      <= CUR_RST;
            oRAMPING <= 1'b0;
        end else begin
            up_sync  <= {up_sync[0], iUP_N};
            dn_sync  <= {dn_sync[0], iDN_N};
            up_last  <= up_sync[1];
            dn_last  <= dn_sync[1];
            vol      <= vol_nxt;
            cnt      <= cnt_nxt;
            armed    <= armed_nxt;
            mute_q   <= iMUTE;
            cur      <= cur_nxt;
            oRAMPING <= (cur_nxt != tgt_nxt);
        end
    end

    assign oVOL = vol;

    genvar g;
    for (g = 0; g < CHANNELS; g++) begin : g_ch
        logic signed [PW-1:0] p_q;
        logic signed [PW-1:0] s;
        logic [PW-WIDTH:0]    hi;
        logic                 fits;

        always_ff @(posedge iCLK) begin
            if (!iRST_N) begin
                p_q <= '0;
            end else if (iSTROBE) begin
                p_q <= PW'($signed(iDATA[g*WIDTH +: WIDTH])) * PW'($signed({1'b0, cur}));
            end
        end

        // value fits WIDTH bits iff all bits above the sign bit agree with it
        assign s    = p_q >>> SH;
        assign hi   = s[PW-1:WIDTH-1];
        assign fits = (&hi) | ~(|hi);
        assign sat_data[g*WIDTH +: WIDTH] = fits ? s[WIDTH-1:0] : (s[PW-1] ? S_MIN : S_MAX);
        assign sat_flag[g] = ~fits;
    end

    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            v1     <= 1'b0;
            oVALID <= 1'b0;
            oDATA  <= '0;
            oSAT   <= '0;
        end else begin
            v1     <= iSTROBE;
            oVALID <= v1;
            if (v1) begin
                oDATA <= sat_data;
                oSAT  <= sat_flag;
            end
        end
    end

endmodule

// File: tb/tb_audio_volume_ramp.sv
// tb/tb_audio_volume_ramp.sv - self-checking bench for audio_volume_ramp
module tb_audio_volume_ramp;

    localparam int RT = 8;
    localparam int SH = 7;

    logic        iCLK = 1'b0;
    logic        iRST_N, iEN, iUP_N, iDN_N, iMUTE, iSTROBE;
    logic [31:0] iDATA;
    logic [31:0] oDATA;
    logic        oVALID;
    logic [1:0]  oSAT;
    logic [3:0]  oVOL;
    logic        oRAMPING;

    audio_volume_ramp #(.REPEAT_TICKS(RT)) dut (
        .iCLK(iCLK), .iRST_N(iRST_N), .iEN(iEN), .iUP_N(iUP_N), .iDN_N(iDN_N),
        .iMUTE(iMUTE), .iSTROBE(iSTROBE), .iDATA(iDATA), .oDATA(oDATA),
        .oVALID(oVALID), .oSAT(oSAT), .oVOL(oVOL), .oRAMPING(oRAMPING)
    );

    always #5 iCLK = ~iCLK;

    int cyc = 0;
    always @(posedge iCLK) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  sat;
        int          cyc;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    typedef struct {
        int          vol;
        int          x0;
        int          x1;
        logic [31:0] d;
        logic [1:0]  s;
    } vec_t;
    vec_t tab[7];

    int n_cmp = 0, n_bad = 0, n_valid = 0;
    int vol_m = 8, cur_m = 128;
    bit mute_m = 1'b0;
    int vb;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    always @(negedge iCLK) begin
        if (oVALID === 1'b1) begin
            n_valid++;
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_valid: got oVALID=1 at cycle %0d required none pending", cyc);
            end else begin
                mon_e = sb.pop_front();
                if (mon_e.cyc != cyc || oDATA !== mon_e.data || oSAT !== mon_e.sat) begin
                    n_bad++;
                    $display("FAIL sample: got cyc=%0d data=%h sat=%b required cyc=%0d data=%h sat=%b",
                             cyc, oDATA, oSAT, mon_e.cyc, mon_e.data, mon_e.sat);
                end
            end
        end
    end

    task automatic model_ch(input int x, output logic [15:0] d, output bit c);
        int q;
        q = (x * cur_m) >>> SH;
        c = 1'b1;
        if (q > 32767) d = 16'h7FFF;
        else if (q < -32768) d = 16'h8000;
        else begin
            d = q[15:0];
            c = 1'b0;
        end
    endtask

    task automatic strobe(input int x0, input int x1, input bit use_tab,
                          input logic [31:0] td, input logic [1:0] ts);
        exp_t e;
        logic [15:0] d0, d1;
        bit c0, c1;
        int tgt;
        @(posedge iCLK);
        #1;
        iSTROBE = 1'b1;
        iDATA   = {x1[15:0], x0[15:0]};
        model_ch(x0, d0, c0);
        model_ch(x1, d1, c1);
        e.data = use_tab ? td : {d1, d0};
        e.sat  = use_tab ? ts : {c1, c0};
        e.cyc  = cyc + 2;
        sb.push_back(e);
        tgt = mute_m ? 0 : vol_m * 16;
        if (cur_m < tgt) cur_m++;
        else if (cur_m > tgt) cur_m--;
    endtask

    task automatic burst(input int n, input int x0, input int x1);
        repeat (n) strobe(x0, x1, 1'b0, '0, '0);
        @(posedge iCLK);
        #1 iSTROBE = 1'b0;
    endtask

    task automatic settle();
        int tgt, n;
        tgt = mute_m ? 0 : vol_m * 16;
        n = (cur_m > tgt) ? cur_m - tgt : tgt - cur_m;
        if (n > 0) burst(n, 0, 0);
    endtask

    task automatic tap(input bit up);
        @(posedge iCLK);
        #1;
        if (up) iUP_N = 1'b0; else iDN_N = 1'b0;
        repeat (5) @(posedge iCLK);
        #1;
        iUP_N = 1'b1;
        iDN_N = 1'b1;
        repeat (5) @(posedge iCLK);
        #1;
        if (iEN) begin
            if (up && vol_m < 15) vol_m++;
            else if (!up && vol_m > 0) vol_m--;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge iCLK);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tab[0] = '{8,  4660,   -4660,  32'hEDCC_1234, 2'b00};
        tab[1] = '{8,  32767,  -32768, 32'h8000_7FFF, 2'b00};
        tab[2] = '{8,  0,      -1,     32'hFFFF_0000, 2'b00};
        tab[3] = '{15, 20000,  -32768, 32'h8000_7FFF, 2'b11};
        tab[4] = '{15, 1000,   0,      32'h0000_0753, 2'b00};
        tab[5] = '{15, -1000,  32767,  32'h7FFF_F8AD, 2'b10};
        tab[6] = '{15, -1,     1,      32'h0001_FFFE, 2'b00};

        iRST_N = 1'b0; iEN = 1'b1; iUP_N = 1'b1; iDN_N = 1'b1;
        iMUTE = 1'b0; iSTROBE = 1'b0; iDATA = '0;
        idle(3);
        iRST_N = 1'b1;
        check("rst_vol", 64'(oVOL), 64'd8);
        check("rst_valid", 64'(oVALID), 64'd0);
        check("rst_data", 64'(oDATA), 64'd0);
        check("rst_sat", 64'(oSAT), 64'd0);
        check("rst_ramping", 64'(oRAMPING), 64'd0);

        // auto-repeat: steps at detect, +8, +16, +24
        @(posedge iCLK); #1 iUP_N = 1'b0;
        idle(5);
        check("repeat_first_step", 64'(oVOL), 64'd9);
        idle(25);
        iUP_N = 1'b1;
        idle(6);
        check("repeat_up_vol", 64'(oVOL), 64'd12);
        iDN_N = 1'b0;
        idle(200);
        iDN_N = 1'b1;
        idle(6);
        check("down_clamp_zero", 64'(oVOL), 64'd0);
        vol_m = 0;
        tap(1'b1);
        check("single_tap", 64'(oVOL), 64'd1);
        iUP_N = 1'b0; iDN_N = 1'b0;
        idle(40);
        iUP_N = 1'b1; iDN_N = 1'b1;
        idle(6);
        check("both_keys_no_step", 64'(oVOL), 64'd1);
        while (vol_m < 8) tap(1'b1);
        check("back_to_8", 64'(oVOL), 64'd8);

        for (int i = 0; i < 7; i++) begin
            while (vol_m < tab[i].vol) tap(1'b1);
            while (vol_m > tab[i].vol) tap(1'b0);
            settle();
            strobe(tab[i].x0, tab[i].x1, 1'b1, tab[i].d, tab[i].s);
            @(posedge iCLK); #1 iSTROBE = 1'b0;
            idle(2);
            check("table_ramping", 64'(oRAMPING), 64'd0);
        end
        tap(1'b1);
        check("up_clamp_max", 64'(oVOL), 64'd15);
        while (vol_m > 8) tap(1'b0);
        settle();

        // one-step ramp 128 -> 144 over 16 strobes
        tap(1'b1);
        burst(15, 1000, -1000);
        check("ramp_mid", 64'(oRAMPING), 64'd1);
        burst(5, 1000, -1000);
        check("ramp_done", 64'(oRAMPING), 64'd0);
        idle(2);
        check("gain_9_8", 64'(oDATA), 64'hFB9B_0465);
        tap(1'b0);
        settle();

        @(posedge iCLK); #1 iMUTE = 1'b1;
        mute_m = 1'b1;
        burst(128, 1000, 1000);
        check("mute_vol_kept", 64'(oVOL), 64'd8);
        check("mute_ramp_done", 64'(oRAMPING), 64'd0);
        burst(1, 12345, -12345);
        idle(2);
        check("mute_data_zero", 64'(oDATA), 64'd0);
        iMUTE = 1'b0;
        mute_m = 1'b0;
        burst(127, 500, -500);
        check("unmute_ramping", 64'(oRAMPING), 64'd1);
        burst(1, 500, -500);
        check("unmute_done", 64'(oRAMPING), 64'd0);

        // reset mid-ramp with one strobe in flight
        tap(1'b1);
        burst(5, 1000, -1000);
        idle(3);
        vb = n_valid;
        iSTROBE = 1'b1; iDATA = 32'h1111_2222;
        @(posedge iCLK); #1 iSTROBE = 1'b0; iRST_N = 1'b0;
        @(posedge iCLK); #1 iRST_N = 1'b1;
        idle(4);
        check("rst_drops_valid", 64'(n_valid), 64'(vb));
        check("rst_mid_vol", 64'(oVOL), 64'd8);
        check("rst_mid_data", 64'(oDATA), 64'd0);
        check("rst_mid_ramping", 64'(oRAMPING), 64'd0);
        vol_m = 8; cur_m = 128; mute_m = 1'b0;
        burst(1, 1000, -1000);
        idle(2);
        check("rst_unity_gain", 64'(oDATA), 64'hFC18_03E8);

        iEN = 1'b0;
        repeat (3) tap(1'b1);
        iDN_N = 1'b0;
        idle(20);
        iDN_N = 1'b1;
        idle(5);
        check("en_low_no_step", 64'(oVOL), 64'd8);
        iUP_N = 1'b0;
        idle(5);
        iEN = 1'b1;
        idle(20);
        check("en_raise_held", 64'(oVOL), 64'd8);
        iUP_N = 1'b1;
        idle(5);
        check("en_raise_release", 64'(oVOL), 64'd8);
        tap(1'b1);
        check("en_tap_after", 64'(oVOL), 64'd9);

        idle(4);
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending outputs required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
